// File: rtl/bsg_fsb_client_egress_pkg.sv
// Shared FSB definitions: client packet layout and the egress state encoding.
package bsg_fsb_pkg;

  typedef struct packed {
    logic [3:0]  destid;
    logic        cmd;
    logic [74:0] data;
  } bsg_fsb_pkt_client_s;

  typedef enum logic [1:0] {
    eOff   = 2'd0,
    eRun   = 2'd1,
    eDrain = 2'd2
  } bsg_fsb_egress_state_e;

endpackage

// File: rtl/bsg_fsb_client_egress_two_fifo.sv
// Two-entry FIFO with valid/ready enqueue and valid/yumi dequeue; head is registered.
module bsg_two_fifo #(
  parameter int unsigned width_p = 80
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem [2];
  logic               wptr, rptr;
  logic [1:0]         count;
  logic               enq, deq;

  assign ready_o = (count != 2'd2);
  assign v_o     = (count != 2'd0);
  assign data_o  = mem[rptr];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (enq) wptr <= ~wptr;
      if (deq) rptr <= ~rptr;
      case ({enq, deq})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk_i) begin
    if (enq) mem[wptr] <= data_i;
  end

endmodule

// File: rtl/bsg_fsb_client_egress.sv
// Credit-gated FSB egress with run/drain/off quiescing.
// Optional send counter: define BSG_FSB_CLIENT_EGRESS_STATS_EN.
module bsg_fsb_client_egress
  import bsg_fsb_pkg::*;
#(
  parameter int unsigned width_p   = $bits(bsg_fsb_pkt_client_s),
  parameter int unsigned credits_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               ready_i,
  input  logic               credit_v_i,
  output logic               idle_o,
  output logic               credit_err_o,
  output logic [15:0]        sent_count_o
);

  localparam int unsigned cw_lp = $clog2(credits_p + 1);
  localparam logic [cw_lp-1:0] credits_full_lp = cw_lp'(credits_p);

  bsg_fsb_egress_state_e state_r, state_n;
  logic [cw_lp-1:0]      credits_r;
  logic                  credit_err_r;
  logic                  fifo_ready, fifo_v, send;

  bsg_two_fifo #(
    .width_p(width_p)
  ) fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .ready_o(fifo_ready),
    .v_i    (yumi_o),
    .data_i (data_i),
    .v_o    (fifo_v),
    .data_o (data_o),
    .yumi_i (send)
  );

  assign yumi_o       = v_i & (state_r == eRun) & fifo_ready;
  assign v_o          = fifo_v & (credits_r != '0) & (state_r != eOff);
  assign send         = v_o & ready_i;
  assign idle_o       = (state_r == eOff);
  assign credit_err_o = credit_err_r;

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= eOff;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      eOff:    if (en_i) state_n = eRun;
      eRun:    if (!en_i) state_n = eDrain;
      eDrain: begin
        if (en_i)                                       state_n = eRun;
        else if (!fifo_v && credits_r == credits_full_lp) state_n = eOff;
      end
      default: state_n = eOff;
    endcase
  end

  // A return with no send at full count is an FSB protocol error; saturate and flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      credits_r    <= credits_full_lp;
      credit_err_r <= 1'b0;
    end else if (send && !credit_v_i) begin
      credits_r <= credits_r - cw_lp'(1);
    end else if (credit_v_i && !send) begin
      if (credits_r == credits_full_lp) credit_err_r <= 1'b1;
      else                              credits_r    <= credits_r + cw_lp'(1);
    end
  end

`ifdef BSG_FSB_CLIENT_EGRESS_STATS_EN
  logic [15:0] sent_count_r;

  always_ff @(posedge clk_i) begin
    if (reset_i)   sent_count_r <= '0;
    else if (send) sent_count_r <= sent_count_r + 16'd1;
  end

  assign sent_count_o = sent_count_r;
`else
  assign sent_count_o = '0;
`endif

endmodule
